// File: rtl/sb_pkg.sv
// Shared types and constants for the posted-write store buffer.
package sb_pkg;

   localparam int unsigned SB_DEPTH_DEF = 4;
   localparam int unsigned SB_AW_DEF    = 32;
   localparam int unsigned SB_DW_DEF    = 32;
   localparam int unsigned SB_PTR_W     = $clog2(SB_DEPTH_DEF);

   typedef struct packed {
      logic [SB_AW_DEF-1:0] addr;
      logic [SB_DW_DEF-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Newest-match search over the valid window [head, head+count) of the store buffer.
module sb_fwd_match
   import sb_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH_DEF,
   parameter int unsigned AW    = SB_AW_DEF,
   parameter int unsigned DW    = SB_DW_DEF
) (
   input  logic [DEPTH-1:0][AW-1:0]  addrs,
   input  logic [DEPTH-1:0][DW-1:0]  datas,
   input  logic [$clog2(DEPTH)-1:0]  head,
   input  logic [$clog2(DEPTH):0]    count,
   input  logic [AW-1:0]             ld_addr,
   output logic                      hit,
   output logic [DW-1:0]             data
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0] idx;

   // Walk oldest to newest so the last match wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (((PW+1)'(i) < count) && (addrs[idx] == ld_addr)) begin
            hit  = 1'b1;
            data = datas[idx];
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: one-cycle store accept, in-order drain, load forwarding.
module store_buffer
   import sb_pkg::*;
#(
   parameter int unsigned DEPTH = SB_DEPTH_DEF,
   parameter int unsigned AW    = SB_AW_DEF,
   parameter int unsigned DW    = SB_DW_DEF
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          CPU_WR,
   input  logic          CPU_RD,
   input  logic [AW-1:0] CPU_Addr,
   input  logic [DW-1:0] CPU_DataIn,
   output logic [DW-1:0] CPU_DataOut,
   output logic          Stall,
   output logic          Empty,
   input  logic          MemGrant,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemDataIn,
   output logic          MemRD,
   output logic          MemWR,
   input  logic [DW-1:0] MemDataOut
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [DEPTH-1:0][AW-1:0] addr_q;
   logic [DEPTH-1:0][DW-1:0] data_q;
   logic [PW-1:0]            head_q, tail_q;
   logic [PW:0]              count_q;

   logic          ld, wr, full, drain, enq, hit;
   logic [DW-1:0] fwd_data;

   // Simultaneous RD and WR is treated as a store; everything is gated while in reset.
   assign ld    = CPU_RD & ~CPU_WR & ~Reset;
   assign wr    = CPU_WR & ~Reset;
   assign full  = (count_q == (PW+1)'(DEPTH));
   assign drain = (count_q != '0) & ~ld & MemGrant & ~Reset;
   assign Stall = (wr & full & ~drain) | (ld & ~hit & ~MemGrant);
   assign enq   = wr & ~Stall;
   assign Empty = (count_q == '0);

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fwd (
      .addrs   (addr_q),
      .datas   (data_q),
      .head    (head_q),
      .count   (count_q),
      .ld_addr (CPU_Addr),
      .hit     (hit),
      .data    (fwd_data)
   );

   always_comb begin
      MemRD       = 1'b0;
      MemWR       = 1'b0;
      MemAddr     = '0;
      MemDataIn   = '0;
      CPU_DataOut = '0;
      if (ld) begin
         MemRD       = MemGrant;
         MemAddr     = CPU_Addr;
         CPU_DataOut = hit ? fwd_data : MemDataOut;
      end else if (drain) begin
         MemWR     = 1'b1;
         MemAddr   = addr_q[head_q];
         MemDataIn = data_q[head_q];
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (drain) head_q <= head_q + PW'(1);
         if (enq)   tail_q <= tail_q + PW'(1);
         if (enq && !drain)      count_q <= count_q + (PW+1)'(1);
         else if (!enq && drain) count_q <= count_q - (PW+1)'(1);
      end
   end

   // Payload storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge CLK) begin
      if (enq) begin
         addr_q[tail_q] <= CPU_Addr;
         data_q[tail_q] <= CPU_DataIn;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded bench: accepted stores queue expected memory writes; a monitor checks each MemWR.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr = 1'b0, rd = 1'b0, grant = 1'b0;
   logic [31:0] addr = '0, din = '0;
   logic [31:0] dout, mem_addr, mem_din, mem_dout;
   logic        stall, empty, mem_rd, mem_wr;

   logic [31:0] mem [64];
   logic [63:0] exp_q [$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   store_buffer dut (
      .CLK         (clk),
      .Reset       (rst),
      .CPU_WR      (wr),
      .CPU_RD      (rd),
      .CPU_Addr    (addr),
      .CPU_DataIn  (din),
      .CPU_DataOut (dout),
      .Stall       (stall),
      .Empty       (empty),
      .MemGrant    (grant),
      .MemAddr     (mem_addr),
      .MemDataIn   (mem_din),
      .MemRD       (mem_rd),
      .MemWR       (mem_wr),
      .MemDataOut  (mem_dout)
   );

   assign mem_dout = mem[mem_addr[5:0]];

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + 32'(i);
   end

   always @(negedge clk) begin
      if (mem_wr) mem[mem_addr[5:0]] <= mem_din;
   end

   // Monitor: every memory write must match the oldest accepted store.
   always @(negedge clk) begin
      if (mem_wr) begin
         logic [63:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL memwr_unexpected: got addr=%h data=%h, required no write",
                     mem_addr, mem_din);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_din} !== e) begin
               errors++;
               $display("FAIL memwr_order: got addr=%h data=%h, required addr=%h data=%h",
                        mem_addr, mem_din, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs 1 ns after the posedge; callers check 2 ns later.
   task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic g);
      @(posedge clk);
      #1;
      wr = w; rd = r; addr = a; din = d; grant = g;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic g,
                     input logic exp_stall);
      cyc(1'b1, 1'b0, a, d, g);
      #2;
      check("store_stall", 32'(stall), 32'(exp_stall));
      if (!exp_stall) exp_q.push_back({a, d});
   endtask

   task automatic idle(input logic g);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, g);
      #2;
   endtask

   initial begin
      // Outputs forced quiet while reset is held, even with a load request pending.
      rd = 1'b1; grant = 1'b1; addr = 32'h9;
      #3;
      check("rst_memrd", 32'(mem_rd), 32'h0);
      check("rst_memwr", 32'(mem_wr), 32'h0);
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_empty", 32'(empty), 32'h1);
      check("rst_memaddr", mem_addr, 32'h0);
      check("rst_dout", dout, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1'b1);
      check("idle_empty", 32'(empty), 32'h1);
      check("idle_memwr", 32'(mem_wr), 32'h0);

      // Reset mid-drain with three pending stores.
      st(32'd10, 32'hD10, 1'b0, 1'b0);
      st(32'd11, 32'hD11, 1'b0, 1'b0);
      st(32'd12, 32'hD12, 1'b0, 1'b0);
      idle(1'b1);
      check("drain_memwr", 32'(mem_wr), 32'h1);
      check("drain_addr", mem_addr, 32'd10);
      idle(1'b1);
      check("drain2_memwr", 32'(mem_wr), 32'h1);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("midrst_memwr", 32'(mem_wr), 32'h0);
      check("midrst_empty", 32'(empty), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1'b1);
      check("postrst_memwr", 32'(mem_wr), 32'h0);
      idle(1'b1);
      check("postrst_empty", 32'(empty), 32'h1);
      check("mem11_untouched", mem[11], 32'h100B);

      // Single store drains in one cycle.
      st(32'd5, 32'h11223344, 1'b1, 1'b0);
      idle(1'b1);
      check("t2_not_empty", 32'(empty), 32'h0);
      idle(1'b1);
      check("t2_empty", 32'(empty), 32'h1);
      check("t2_mem5", mem[5], 32'h11223344);

      // Same-address stores: forward newest, drain both in order.
      st(32'd2, 32'hA1, 1'b0, 1'b0);
      st(32'd2, 32'hA2, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'd2, 32'h0, 1'b0);
      #2;
      check("t3_fwd_stall", 32'(stall), 32'h0);
      check("t3_fwd_data", dout, 32'hA2);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      check("t3_empty", 32'(empty), 32'h1);
      check("t3_mem2", mem[2], 32'hA2);

      // Fill, stall when full, accept when full-and-draining, wrap pointers.
      for (int i = 0; i < 4; i++) st(32'h20 + 32'(i), 32'hB0 + 32'(i), 1'b0, 1'b0);
      st(32'h24, 32'hB4, 1'b0, 1'b1);
      st(32'h24, 32'hB4, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) st(32'h25 + 32'(i), 32'hC0 + 32'(i), 1'b1, 1'b0);
      st(32'h2F, 32'hEE, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      idle(1'b1);
      check("t4_empty", 32'(empty), 32'h1);
      check("t4_mem2c", mem[6'h2C], 32'hC7);

      // Load miss defers the pending drain; without grant it stalls; head entry forwards.
      st(32'd7, 32'h77, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'd9, 32'h0, 1'b1);
      #2;
      check("t5_memrd", 32'(mem_rd), 32'h1);
      check("t5_memwr", 32'(mem_wr), 32'h0);
      check("t5_memaddr", mem_addr, 32'd9);
      check("t5_dout", dout, 32'h1009);
      check("t5_stall", 32'(stall), 32'h0);
      cyc(1'b0, 1'b1, 32'd9, 32'h0, 1'b0);
      #2;
      check("t5_nogrant_stall", 32'(stall), 32'h1);
      check("t5_nogrant_memrd", 32'(mem_rd), 32'h0);
      cyc(1'b0, 1'b1, 32'd7, 32'h0, 1'b0);
      #2;
      check("t5_head_fwd", dout, 32'h77);
      check("t5_head_stall", 32'(stall), 32'h0);
      idle(1'b1);

      // WR and RD together behave as a store only.
      cyc(1'b1, 1'b1, 32'h30, 32'hC6, 1'b0);
      #2;
      check("t6_dout", dout, 32'h0);
      check("t6_memrd", 32'(mem_rd), 32'h0);
      check("t6_stall", 32'(stall), 32'h0);
      exp_q.push_back({32'h30, 32'hC6});
      cyc(1'b0, 1'b1, 32'h30, 32'h0, 1'b0);
      #2;
      check("t6_fwd", dout, 32'hC6);
      idle(1'b1);
      idle(1'b1);
      check("end_empty", 32'(empty), 32'h1);
      check("end_queue", 32'(exp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the CPU load/store path and the word-addressed data memory.
- Accepts stores in one cycle and drains them to memory whenever the memory port is granted and not needed for a load.
- Forwards buffered data to younger loads of the same word address.
- Shields the single-cycle datapath from a shared memory port (fetch/DMA arbiter supplies MemGrant).

Parameters:
- DEPTH, 4, number of buffered stores; power of two, >= 2.
- AW, 32, address width. Address is a word index, the same index the data memory takes.
- DW, 32, data width.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- CPU_WR  in  1  store request this cycle.
- CPU_RD  in  1  load request this cycle.
- CPU_Addr  in  AW  word address of the load/store.
- CPU_DataIn  in  DW  store data.
- CPU_DataOut  out  DW  load data (combinational).
- Stall  out  1  store not accepted this cycle; CPU must hold the instruction.
- Empty  out  1  no pending stores; used by halt/fence logic.
- MemGrant  in  1  arbiter allows this block to drive the memory port this cycle.
- MemAddr  out  AW  word address to memory.
- MemDataIn  out  DW  write data to memory.
- MemRD  out  1  memory read enable.
- MemWR  out  1  memory write enable; memory commits on negedge CLK.
- MemDataOut  in  DW  memory read data.

Behaviour:
- Storage: circular array of {addr, data}. State is head ptr, tail ptr and count (0..DEPTH). Full = (count == DEPTH).
- Reset (async, any time): count = 0, head = tail = 0. All pending stores are discarded and none reach memory.
- Output values while Reset is held: MemWR = 0, MemRD = 0, Stall = 0, Empty = 1, MemAddr = 0, MemDataIn = 0, CPU_DataOut = 0.
- Port mux, combinational, priority order:
  1. CPU_RD = 1 (load): MemRD = MemGrant, MemAddr = CPU_Addr, MemWR = 0.
  2. count > 0, CPU_RD = 0, MemGrant = 1 (drain): MemWR = 1, MemAddr = head.addr, MemDataIn = head.data.
  3. Otherwise: MemRD = MemWR = 0, MemAddr = 0, MemDataIn = 0.
- Drain pop: head advances and count decrements at the posedge ending a drain cycle. Memory has already written at the mid-cycle negedge.
- Enqueue: CPU_WR = 1 and Stall = 0. Entry written at tail at posedge; tail advances; count increments.
- Stall = CPU_WR & Full & ~drain. If full and draining in the same cycle, the store is accepted; count stays DEPTH.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- Pointer wrap: DEPTH-1 -> 0.
- Load forwarding:
  - If CPU_RD = 1 and any valid entry has addr == CPU_Addr, CPU_DataOut = data of the newest matching entry (closest to tail).
  - Otherwise CPU_DataOut = MemDataOut.
  - Forwarding covers all valid entries, including the head.
- Load stall: if CPU_RD = 1, no forward hit and MemGrant = 0, Stall = 1.
- CPU_DataOut = 0 whenever CPU_RD = 0.
- Load/store latency:
  - A store is visible to forwarding from the cycle after acceptance.
  - A load completes in the same cycle unless it stalls.
- CPU_WR = CPU_RD = 1 is illegal. The block treats it as a store only: load ignored, CPU_DataOut = 0.
- Empty = (count == 0), a registered-state decode.
- Same-address stores: both entries are kept and drain in order. Forwarding returns the newest.

Decomposition:
- Shared package sb_pkg holds:
  - typedef sb_entry_t {addr[AW-1:0], data[DW-1:0]};
  - constants SB_DEPTH_DEF = 4 and SB_PTR_W = clog2(DEPTH).
- One sub-module, sb_fwd_match: combinational newest-match priority search over valid entries. Inputs are the array, head, count and the load address. Outputs are hit and data.

Test Plan:
1. Reset then idle: Empty = 1, MemWR = 0, Stall = 0. Assert Reset mid-drain with count = 3: MemWR drops immediately, Empty = 1, no further memory writes.
2. Store 0x11223344 @ addr 5 with MemGrant = 1, then NOP: memory word 5 = 0x11223344 after one drain cycle; Empty returns to 1.
3. MemGrant = 0; stores A1 @ 2, then A2 @ 2; load @ 2 -> CPU_DataOut = A2 with no stall. Then grant: memory word 2 ends at A2 after two ordered writes.
4. MemGrant = 0; 4 stores fill the buffer; 5th store -> Stall = 1. Raise MemGrant -> 5th store accepted that cycle, count stays 4, and the pointers wrap correctly across 8 more stores.
5. Load @ 9 with no match and MemGrant = 1 -> MemRD = 1, CPU_DataOut = memory word 9, pending drain deferred. Same load with MemGrant = 0 -> Stall = 1.
6. CPU_WR = CPU_RD = 1 -> store enqueued, CPU_DataOut = 0, MemRD = 0.
